// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes and registered
// Z/N/C/V flags. Single-cycle ops produce a result the cycle after they are
// accepted. MUL runs as an iterative shift-add over WIDTH cycles.
// Ports:
//   clk, rst_n                         clock (rising edge), async active-low reset
//   in_valid_i / in_ready_o            input handshake (opcode_i, op_a_i, op_b_i)
//   out_valid_o / out_ready_i          output handshake (result_o, result_hi_o, flags)
//   result_o, result_hi_o              result; high half is MUL only, 0 otherwise
//   flag_z_o/flag_n_o/flag_c_o/flag_v_o zero, negative, carry/borrow, signed overflow
//   busy_o                             MUL iteration in progress
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       opcode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             flag_z_o,
  output logic             flag_n_o,
  output logic             flag_c_o,
  output logic             flag_v_o,
  output logic             busy_o
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int M   = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'h0, OP_AND = 4'h1, OP_NOT = 4'h2, OP_ADDC = 4'h3,
                         OP_XOR  = 4'h4, OP_SUB = 4'h5, OP_OR  = 4'h6, OP_SHL  = 4'h7,
                         OP_SHR  = 4'h8, OP_MUL = 4'h9;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FULL} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             z_q, n_q, c_q, v_q;
  logic [WIDTH-1:0] mcand_q, acc_hi_q, acc_lo_q;
  logic [CW-1:0]    cnt_q;

  logic accept, is_mul, mul_last;
  assign accept   = in_valid_i & in_ready_o;
  assign is_mul   = (opcode_i == OP_MUL);
  assign mul_last = (state_q == S_BUSY) && (cnt_q == CW'(1));

  // Single-cycle datapath
  logic [WIDTH:0]   add_sum, sub_diff, shl_w, shr_w;
  logic [SHW-1:0]   sh;
  logic             cin;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  // ADDC chains off the registered carry, i.e. the last completed op's C.
  assign cin      = (opcode_i == OP_ADDC) & c_q;
  assign add_sum  = {1'b0, op_a_i} + {1'b0, op_b_i} + {{WIDTH{1'b0}}, cin};
  assign sub_diff = {1'b0, op_a_i} - {1'b0, op_b_i};
  assign sh       = op_b_i[SHW-1:0];
  // One extra bit on the outgoing side catches the last bit shifted out;
  // a zero shift leaves it 0.
  assign shl_w    = {1'b0, op_a_i} << sh;
  assign shr_w    = {op_a_i, 1'b0} >> sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode_i)
      OP_ADD, OP_ADDC: begin
        alu_res = add_sum[M:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (op_a_i[M] == op_b_i[M]) & (alu_res[M] != op_a_i[M]);
      end
      OP_SUB: begin
        alu_res = sub_diff[M:0];
        alu_c   = sub_diff[WIDTH];
        alu_v   = (op_a_i[M] != op_b_i[M]) & (alu_res[M] != op_a_i[M]);
      end
      OP_AND: alu_res = op_a_i & op_b_i;
      OP_OR:  alu_res = op_a_i | op_b_i;
      OP_XOR: alu_res = op_a_i ^ op_b_i;
      OP_NOT: alu_res = ~op_a_i;
      OP_SHL: begin
        alu_res = shl_w[M:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: ; // reserved: zero result, so Z=1 falls out below
    endcase
  end

  // Shift-add step: conditionally add the multiplicand into the high half,
  // then shift {carry, hi, lo} right one place. The multiplier is consumed
  // from the low half as the product fills in from the top.
  logic [WIDTH:0]   mstep;
  logic [WIDTH-1:0] mhi_d, mlo_d;
  assign mstep = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
  assign mhi_d = mstep[WIDTH:1];
  assign mlo_d = {mstep[0], acc_lo_q[M:1]};

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    case (state_q)
      S_IDLE: in_ready_o = 1'b1;
      S_FULL: in_ready_o = out_ready_i;
      default: ;
    endcase
    case (state_q)
      S_IDLE, S_FULL: begin
        if (accept)                 state_d = is_mul ? S_BUSY : S_FULL;
        else if (state_q == S_FULL && out_ready_i) state_d = S_IDLE;
      end
      S_BUSY: if (mul_last) state_d = S_FULL;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      mcand_q     <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (is_mul) begin
          mcand_q  <= op_a_i;
          acc_hi_q <= '0;
          acc_lo_q <= op_b_i;
          cnt_q    <= CW'(WIDTH);
        end else begin
          result_q    <= alu_res;
          result_hi_q <= '0;
          z_q         <= (alu_res == '0);
          n_q         <= alu_res[M];
          c_q         <= alu_c;
          v_q         <= alu_v;
        end
      end else if (state_q == S_BUSY) begin
        acc_hi_q <= mhi_d;
        acc_lo_q <= mlo_d;
        cnt_q    <= cnt_q - CW'(1);
        if (mul_last) begin
          result_q    <= mlo_d;
          result_hi_q <= mhi_d;
          z_q         <= ({mhi_d, mlo_d} == '0);
          n_q         <= mhi_d[M];
          c_q         <= (mhi_d != '0);
          v_q         <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o = (state_q == S_FULL);
  assign busy_o      = (state_q == S_BUSY);
  assign result_o    = result_q;
  assign result_hi_o = result_hi_q;
  assign flag_z_o    = z_q;
  assign flag_n_o    = n_q;
  assign flag_c_o    = c_q;
  assign flag_v_o    = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): one task per scenario, inline checks.
module tb_alu_seq;
  logic       clk, rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] opcode;
  logic [7:0] op_a, op_b, result, result_hi;
  logic       fz, fn, fc, fv;
  int checks = 0, failures = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opcode_i(opcode), .op_a_i(op_a), .op_b_i(op_b), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .result_hi_o(result_hi),
    .flag_z_o(fz), .flag_n_o(fn), .flag_c_o(fc), .flag_v_o(fv), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one accepting edge, then drop in_valid.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; opcode = op; op_a = a; op_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 4'h0; op_a = 8'h00; op_b = 8'h00;
    tick(); tick();
    checks++;
    if ({out_valid, busy, result, result_hi, fz, fn, fc, fv} !== 22'h0) begin
      failures++;
      $display("FAIL reset_state: got ov=%b busy=%b res=%h hi=%h zncv=%b%b%b%b, want all 0",
               out_valid, busy, result, result_hi, fz, fn, fc, fv);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_addc();
    out_ready = 1'b1;
    send(4'h0, 8'hFF, 8'h01);
    checks++;
    if ({out_valid, result, fz, fn, fc, fv} !== {1'b1, 8'h00, 4'b1010}) begin
      failures++;
      $display("FAIL add_ff_01: got ov=%b res=%h zncv=%b%b%b%b, want ov=1 res=00 zncv=1010",
               out_valid, result, fz, fn, fc, fv);
    end
    send(4'h3, 8'h00, 8'h00);
    checks++;
    if ({out_valid, result, fz, fn, fc, fv} !== {1'b1, 8'h01, 4'b0000}) begin
      failures++;
      $display("FAIL addc_carry_in: got ov=%b res=%h zncv=%b%b%b%b, want ov=1 res=01 zncv=0000",
               out_valid, result, fz, fn, fc, fv);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_idle: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    send(4'h5, 8'h80, 8'h01);
    checks++;
    if ({result, fz, fn, fc, fv} !== {8'h7F, 4'b0001}) begin
      failures++;
      $display("FAIL sub_80_01: got res=%h zncv=%b%b%b%b want res=7f zncv=0001", result, fz, fn, fc, fv);
    end
    send(4'h5, 8'h00, 8'h01);
    checks++;
    if ({result, fz, fn, fc, fv} !== {8'hFF, 4'b0110}) begin
      failures++;
      $display("FAIL sub_00_01: got res=%h zncv=%b%b%b%b want res=ff zncv=0110", result, fz, fn, fc, fv);
    end
    // ADDC after a borrow: 05+03+1 = 09
    send(4'h3, 8'h05, 8'h03);
    checks++;
    if ({result, fc} !== {8'h09, 1'b0}) begin
      failures++;
      $display("FAIL addc_after_borrow: got res=%h c=%b want res=09 c=0", result, fc);
    end
    tick();
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    send(4'h9, 8'hFF, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
        failures++;
        $display("FAIL mul_busy_cyc%0d: got busy=%b in_ready=%b ov=%b want 1 0 0", i, busy, in_ready, out_valid);
      end
      tick();
    end
    checks++;
    if ({out_valid, busy, result_hi, result, fz, fn, fc, fv} !== {2'b10, 8'hFE, 8'h01, 4'b0110}) begin
      failures++;
      $display("FAIL mul_ff_ff: got ov=%b busy=%b hi=%h lo=%h zncv=%b%b%b%b want ov=1 busy=0 hi=fe lo=01 zncv=0110",
               out_valid, busy, result_hi, result, fz, fn, fc, fv);
    end
    tick();
    // Small product: 0D*0B = 008F, high half zero so C=0
    send(4'h9, 8'h0D, 8'h0B);
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if ({out_valid, result_hi, result, fz, fn, fc} !== {1'b1, 8'h00, 8'h8F, 3'b000}) begin
      failures++;
      $display("FAIL mul_0d_0b: got ov=%b hi=%h lo=%h znc=%b%b%b want ov=1 hi=00 lo=8f znc=000",
               out_valid, result_hi, result, fz, fn, fc);
    end
    // Non-MUL op after MUL clears result_hi
    send(4'h1, 8'hF0, 8'h3C);
    checks++;
    if ({result_hi, result} !== {8'h00, 8'h30}) begin
      failures++;
      $display("FAIL hi_cleared: got hi=%h res=%h want hi=00 res=30", result_hi, result);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [6];
    logic [7:0] as  [6];
    logic [7:0] bs  [6];
    logic [7:0] exp [6];
    logic       expc[6];
    ops = '{4'h1, 4'h6, 4'h4, 4'h7, 4'h8, 4'h2};
    as  = '{8'hF0, 8'hF0, 8'hFF, 8'h01, 8'h81, 8'h0F};
    bs  = '{8'h3C, 8'h0F, 8'h0F, 8'h03, 8'h01, 8'h00};
    exp = '{8'h30, 8'hFF, 8'hF0, 8'h08, 8'h40, 8'hF0};
    expc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      opcode = ops[i]; op_a = as[i]; op_b = bs[i];
      tick();
      checks++;
      if ({out_valid, result, fc, fv} !== {1'b1, exp[i], expc[i], 1'b0}) begin
        failures++;
        $display("FAIL b2b_op%0d: got ov=%b res=%h c=%b v=%b want ov=1 res=%h c=%b v=0",
                 i, out_valid, result, fc, fv, exp[i], expc[i]);
      end
    end
    in_valid = 1'b0;
    // SHL 81<<1 -> 02, c=1 (bit 7 shifted out)
    send(4'h7, 8'h81, 8'h01);
    checks++;
    if ({result, fc} !== {8'h02, 1'b1}) begin
      failures++;
      $display("FAIL shl_81_1: got res=%h c=%b want res=02 c=1", result, fc);
    end
    send(4'h8, 8'h81, 8'h00);
    checks++;
    if ({result, fc} !== {8'h81, 1'b0}) begin
      failures++;
      $display("FAIL shr_zero_amt: got res=%h c=%b want res=81 c=0", result, fc);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'h0, 8'h10, 8'h20);
    in_valid = 1'b1; opcode = 4'h4; op_a = 8'h55; op_b = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, in_ready, result} !== {2'b10, 8'h30}) begin
        failures++;
        $display("FAIL stall_cyc%0d: got ov=%b in_ready=%b res=%h want ov=1 in_ready=0 res=30",
                 i, out_valid, in_ready, result);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, result, fn} !== {1'b1, 8'hFF, 1'b1}) begin
      failures++;
      $display("FAIL release_second_op: got ov=%b res=%h n=%b want ov=1 res=ff n=1", out_valid, result, fn);
    end
    tick();
  endtask

  task automatic test_reserved();
    out_ready = 1'b1;
    send(4'h0, 8'hFF, 8'h01); // leave C=1 beforehand
    send(4'hC, 8'h12, 8'h34);
    checks++;
    if ({out_valid, result, result_hi, fz, fn, fc, fv} !== {1'b1, 16'h0000, 4'b1000}) begin
      failures++;
      $display("FAIL reserved_op: got ov=%b res=%h hi=%h zncv=%b%b%b%b want ov=1 res=00 hi=00 zncv=1000",
               out_valid, result, result_hi, fz, fn, fc, fv);
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    send(4'h0, 8'hFF, 8'h01); // flags z=1 c=1 held into the MUL
    send(4'h9, 8'h03, 8'h05);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, result, fz, fn, fc, fv} !== 13'h0) begin
      failures++;
      $display("FAIL reset_mid_mul: got ov=%b busy=%b res=%h zncv=%b%b%b%b want all 0",
               out_valid, busy, result, fz, fn, fc, fv);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
        failures++;
        $display("FAIL no_stale_mul_cyc%0d: got ov=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
    send(4'h0, 8'h02, 8'h03);
    checks++;
    if ({out_valid, result, fz, fc} !== {1'b1, 8'h05, 2'b00}) begin
      failures++;
      $display("FAIL post_reset_add: got ov=%b res=%h z=%b c=%b want ov=1 res=05 z=0 c=0", out_valid, result, fz, fc);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add_addc();
    test_sub();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_reserved();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
